// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams a program image into the instruction memory. Bytes arrive over a
// valid/ready handshake and are packed four at a time into 32-bit words,
// with the first byte in the MSB. The fetch path reads PC..PC+3 big-endian,
// so it sees the bytes in the order they arrived. Each word is written to
// consecutive word-aligned addresses, starting at a programmed base address.
//
// Ports:
//   CLK        single clock, all state changes on posedge
//   RESET      asynchronous, active-low reset
//   start      one-cycle load request, sampled only in IDLE
//   base_addr  first byte address of the load (must be word aligned)
//   num_words  number of 32-bit words to load (0..MAX_WORDS)
//   abort      cancels an in-progress load (LOAD/WRITE/DONE)
//   in_valid   byte available
//   in_data    byte value
//   in_ready   loader accepts a byte this cycle
//   mem_we     one-cycle memory write strobe
//   mem_addr   byte address of the word being written
//   mem_wdata  assembled big-endian word
//   busy       high in any state other than IDLE
//   done       one-cycle pulse on successful completion
//   err        sticky error flag, cleared by the next accepted start
//   checksum   sum mod 256 of all bytes accepted in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [1:0]       state;
  logic [31:0]      addr_q;     // address of the word currently being built
  logic [23:0]      word_q;     // first three bytes of the word, oldest in MSB
  logic [1:0]       byte_cnt;   // bytes already accepted for the current word
  logic [CNT_W-1:0] remaining;  // words still to be written, including current

  logic bad_req;
  logic byte_xfer;

  assign bad_req = (base_addr[1:0] != 2'b00) || (num_words > MAX_CNT);

  // NOTE: strobes are decoded combinationally from state so that abort can
  // suppress them in the very cycle it is raised, without a registered lag.
  // in_ready is gated by abort too, so a byte is never reported as taken
  // during the cycle that discards the load.
  assign in_ready  = (state == S_LOAD) && !abort;
  assign mem_we    = (state == S_WRITE) && !abort;
  assign done      = (state == S_DONE) && !abort;
  assign busy      = (state != S_IDLE);
  assign byte_xfer = in_valid && in_ready;

  // NOTE: every register, datapath included, sits on the async reset so a
  // reset mid-load leaves no stale address/word visible on the outputs.
  // Sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // abort is ignored here, so start wins when both are high.
          if (start) begin
            if (bad_req) begin
              err <= 1'b1;
            end else if (num_words == '0) begin
              checksum <= '0;
              err      <= 1'b0;
              state    <= S_DONE;
            end else begin
              addr_q    <= base_addr;
              remaining <= num_words;
              checksum  <= '0;
              err       <= 1'b0;
              byte_cnt  <= '0;
              state     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (abort) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (byte_xfer) begin
            // Shifting left keeps the first byte of the word in the MSB.
            word_q   <= {word_q[15:0], in_data};
            checksum <= checksum + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Capture the finished word into the output registers now,
              // so they are stable during WRITE and hold afterwards.
              mem_addr  <= addr_q;
              mem_wdata <= {word_q, in_data};
              state     <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (abort) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            addr_q    <= addr_q + 32'd4;
            remaining <= remaining - ONE_CNT;
            byte_cnt  <= '0;
            state     <= (remaining == ONE_CNT) ? S_DONE : S_LOAD;
          end
        end

        default: begin  // S_DONE
          if (abort) begin
            err <= 1'b1;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboard bench for imem_loader. Each load pushes the memory writes it
// should produce (computed from the byte list with plain arithmetic) onto
// exp_q. An independent monitor pops and compares on every mem_we. It also
// checks strobe spacing, that in_ready is low during a write, and that done
// follows the last write by one cycle.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MAX_WORDS = 256;
  localparam int CNT_W     = 16;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] num_words;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       checksum;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int last_we_cycle = 0;
  bit have_prev_we  = 1'b0;
  int done_pulses   = 0;
  bit zero_load     = 1'b0;

  logic [63:0] exp_q[$];   // {addr, wdata} of each expected write
  logic [7:0]  byte_q[$];  // bytes to stream for the next load
  int          gap_q[$];   // optional idle cycles before each byte

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cycle++;

  // Monitor: compares every write strobe and done pulse against the model.
  always @(negedge CLK) begin
    if (RESET) begin
      if (mem_we) begin
        check("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
        if (have_prev_we)
          check("min_5_cycles_between_writes",
                {31'd0, (cycle - last_we_cycle) >= 5}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[63:32]);
          check("write_data", mem_wdata, e[31:0]);
        end
        last_we_cycle = cycle;
        have_prev_we  = 1'b1;
      end
      if (done) begin
        done_pulses++;
        if (!zero_load)
          check("done_one_cycle_after_write", cycle - last_we_cycle, 32'd1);
      end
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic do_start(input logic [31:0] base, input int n);
    start     = 1'b1;
    base_addr = base;
    num_words = CNT_W'(n);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge CLK); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
  endtask

  // Full successful load of n words from byte_q; also pushes the expected
  // writes and checks the final status.
  task automatic run_load(input logic [31:0] base, input int n,
                          input int max_gap, input bit with_abort);
    logic [7:0] sum;
    int d0, gap;
    sum = 8'd0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({base + 32'(4 * i),
                       byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]});
    for (int k = 0; k < 4 * n; k++) sum = sum + byte_q[k];
    d0 = done_pulses;
    zero_load = 1'b0;
    abort = with_abort;   // start must win over abort in IDLE
    do_start(base, n);
    abort = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4 * n; k++) begin
      gap = (k < gap_q.size()) ? gap_q[k] : $urandom_range(0, max_gap);
      send_byte(byte_q[k], gap);
    end
    wait_done();
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("err_after_load", {31'd0, err}, 32'd0);
    check("checksum", {24'd0, checksum}, {24'd0, sum});
    check("done_pulse_count", done_pulses - d0, 32'd1);
    check("all_writes_seen", exp_q.size(), 32'd0);
    byte_q.delete();
    gap_q.delete();
  endtask

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int k = 0; k < 4 * n; k++) byte_q.push_back(8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [7:0] sum;
    RESET = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_checksum", {24'd0, checksum}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;

    // Single word.
    byte_q = '{8'h08, 8'h01, 8'h10, 8'h20};
    run_load(32'h0, 1, 0, 1'b0);
    check("single_checksum_0x39", {24'd0, checksum}, 32'h39);

    // Three words at 0x10, in_valid held high.
    byte_q = '{8'h00, 8'h64, 8'h28, 8'h24, 8'h05, 8'h27, 8'h40, 8'h25,
               8'h19, 8'h2A, 8'h58, 8'h22};
    gap_q  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_load(32'h10, 3, 0, 1'b0);

    // Backpressure: every other cycle plus a 7-cycle gap.
    byte_q = '{8'h08, 8'h01, 8'h10, 8'h20};
    gap_q  = '{1, 1, 7, 1};
    run_load(32'h0, 1, 0, 1'b0);

    // Abort after 2 bytes of word 2 of a 3-word load.
    fill_random(3);
    exp_q.push_back({32'h100, byte_q[0], byte_q[1], byte_q[2], byte_q[3]});
    sum = 8'd0;
    for (int k = 0; k < 6; k++) sum = sum + byte_q[k];
    d0 = done_pulses;
    do_start(32'h100, 3);
    for (int k = 0; k < 6; k++) send_byte(byte_q[k], $urandom_range(0, 2));
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    @(negedge CLK);
    check("abort_err", {31'd0, err}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_checksum", {24'd0, checksum}, {24'd0, sum});
    repeat (3) @(posedge CLK);
    #1;
    check("abort_no_done", done_pulses - d0, 32'd0);
    check("abort_only_word1", exp_q.size(), 32'd0);
    fill_random(1);
    run_load(32'h200, 1, 1, 1'b0);   // new start clears err

    // Abort during WRITE suppresses the strobe.
    fill_random(1);
    d0 = done_pulses;
    do_start(32'h40, 1);
    for (int k = 0; k < 4; k++) send_byte(byte_q[k], 0);
    abort = 1'b1;
    @(negedge CLK);
    check("abort_in_write_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge CLK); #1;
    abort = 1'b0;
    @(negedge CLK);
    check("abort_write_err", {31'd0, err}, 32'd1);
    check("abort_write_busy", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1;
    check("abort_write_no_done", done_pulses - d0, 32'd0);

    // Illegal requests.
    do_start(32'h2, 1);
    @(negedge CLK);
    check("misaligned_err", {31'd0, err}, 32'd1);
    check("misaligned_busy", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1;
    fill_random(1);
    run_load(32'h0, 1, 0, 1'b0);
    do_start(32'h0, MAX_WORDS + 1);
    @(negedge CLK);
    check("too_many_err", {31'd0, err}, 32'd1);
    check("too_many_busy", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1;
    zero_load = 1'b1;
    d0 = done_pulses;
    do_start(32'h0, 0);
    @(negedge CLK);
    check("zero_words_done", {31'd0, done}, 32'd1);
    check("zero_words_err_cleared", {31'd0, err}, 32'd0);
    @(posedge CLK); #1;
    check("zero_words_done_count", done_pulses - d0, 32'd1);
    check("zero_words_busy", {31'd0, busy}, 32'd0);
    zero_load = 1'b0;

    // start and abort together in IDLE: start wins.
    fill_random(2);
    run_load(32'h300, 2, 1, 1'b1);

    // Async reset between posedges in LOAD.
    fill_random(2);
    do_start(32'h400, 2);
    send_byte(byte_q[0], 0);
    send_byte(byte_q[1], 0);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("async_rst_checksum", {24'd0, checksum}, 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    check("async_rst_mem_wdata", mem_wdata, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    fill_random(1);
    run_load(32'h0, 1, 0, 1'b0);

    // Randomised loads, some wrapping the top of the address space.
    for (int it = 0; it < 16; it++) begin
      logic [31:0] b;
      int n;
      n = $urandom_range(1, 6);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00};
      fill_random(n);
      run_load(b, n, 3, 1'b0);
    end

    repeat (5) @(posedge CLK);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
